// File: rtl/cam_pkg.sv
// Shared definitions for the DVP capture path: pixel format codes, the
// capture state encoding and the channel-widening helpers used to build
// RGB888 from 5- and 6-bit colour fields.
package cam_pkg;

  localparam logic [1:0] FMT_RGB565 = 2'd0;
  localparam logic [1:0] FMT_RGB555 = 2'd1;
  localparam logic [1:0] FMT_YUV422 = 2'd2;
  localparam logic [1:0] FMT_RAW    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SYNC   = 2'd2,
    ST_ACTIVE = 2'd3
  } cap_state_t;

  // Widen a 5-bit channel to 8 bits by replicating its top bits into the LSBs.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Widen a 6-bit channel to 8 bits by replicating its top bits into the LSBs.
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/pix_fmt_conv.sv
// Combinational pixel format converter.
// Ports:
//   fmt     - pixel format code (cam_pkg FMT_*)
//   hi_byte - first byte of a 2-byte pixel (Y byte in YUV422)
//   lo_byte - second byte of a 2-byte pixel, or the whole pixel in RAW
//   rgb     - {R,G,B} RGB888 result
module pix_fmt_conv
  import cam_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [7:0]  hi_byte,
  input  logic [7:0]  lo_byte,
  output logic [23:0] rgb
);

  // Select the channel layout of the current format and widen to RGB888.
  always_comb begin
    rgb = 24'h000000;
    case (fmt)
      FMT_RGB565: rgb = {expand5(hi_byte[7:3]),
                         expand6({hi_byte[2:0], lo_byte[7:5]}),
                         expand5(lo_byte[4:0])};
      // Bit 15 of an RGB555 word carries no colour and is dropped.
      FMT_RGB555: rgb = {expand5(hi_byte[6:2]),
                         expand5({hi_byte[1:0], lo_byte[7:5]}),
                         expand5(lo_byte[4:0])};
      // Luma only: the chroma byte never reaches the output.
      FMT_YUV422: rgb = {hi_byte, hi_byte, hi_byte};
      FMT_RAW:    rgb = {lo_byte, lo_byte, lo_byte};
      default:    rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP camera front-end: frame-aligns capture to vsync, assembles camera
// bytes into pixels, converts them to RGB888, crops and reports framing
// errors. Output stream carries sof / eol / eof markers.
// Ports:
//   i_pclk, i_cam_rst         - pixel clock, async active-high reset
//   i_init_done, i_enable     - sensor ready / capture enable
//   i_fmt                     - 0 RGB565, 1 RGB555, 2 YUV422, 3 RAW
//   i_pdata, i_vsync, i_href  - camera bus
//   i_crop_*, i_exp_width     - per-frame crop window and expected line width
//   i_err_clr                 - clears sticky error flags
//   o_pix, o_pix_valid        - RGB888 pixel stream
//   o_sof, o_eol, o_eof       - frame/line markers
//   o_frame_active            - capture state is ACTIVE
//   o_frame_cnt               - completed frames (wraps)
//   o_err_len, o_err_odd      - sticky line-length / odd-byte errors
module dvp_pixel_capture
  import cam_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 12
) (
  input  logic               i_pclk,
  input  logic               i_cam_rst,
  input  logic               i_init_done,
  input  logic               i_enable,
  input  logic [1:0]         i_fmt,
  input  logic [DATA_W-1:0]  i_pdata,
  input  logic               i_vsync,
  input  logic               i_href,
  input  logic [COORD_W-1:0] i_crop_x0,
  input  logic [COORD_W-1:0] i_crop_y0,
  input  logic [COORD_W-1:0] i_crop_w,
  input  logic [COORD_W-1:0] i_crop_h,
  input  logic [COORD_W-1:0] i_exp_width,
  input  logic               i_err_clr,
  output logic [23:0]        o_pix,
  output logic               o_pix_valid,
  output logic               o_sof,
  output logic               o_eol,
  output logic               o_eof,
  output logic               o_frame_active,
  output logic [15:0]        o_frame_cnt,
  output logic               o_err_len,
  output logic               o_err_odd
);

  localparam logic [COORD_W-1:0] COL_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COL_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] COL_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COL_NEAR = {{(COORD_W-1){1'b1}}, 1'b0};

  logic [7:0]         byte_q, hold_byte;
  logic               href_q, href_d, vsync_q, vsync_d;
  logic               href_rise, href_fall, vs_rise, vs_fall;
  cap_state_t         state, state_nxt;
  logic [1:0]         cfg_fmt;
  logic [COORD_W-1:0] cfg_x0, cfg_y0, cfg_w, cfg_h, cfg_exp;
  logic               phase, line_emit, sof_pend;
  logic [COORD_W-1:0] col, row;
  logic               byte_ok, two_byte, cur_phase, pix_done, emit;
  logic [COORD_W-1:0] cur_col;
  logic [COORD_W:0]   x_ext, y_ext, x0_ext, y0_ext, x_end, y_end;
  logic               in_x, in_y, frame_start, frame_end, line_end;
  logic               set_len, set_odd;
  logic [23:0]        rgb;

  // Register the camera bus once and keep a delayed copy for edge detection.
  always_ff @(posedge i_pclk or posedge i_cam_rst) begin
    if (i_cam_rst) begin
      byte_q  <= 8'h00;
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      byte_q  <= i_pdata[DATA_W-1 -: 8];
      href_q  <= i_href;
      href_d  <= href_q;
      vsync_q <= i_vsync;
      vsync_d <= vsync_q;
    end
  end

  assign href_rise = href_q & ~href_d;
  assign href_fall = ~href_q & href_d;
  assign vs_rise   = vsync_q & ~vsync_d;
  assign vs_fall   = ~vsync_q & vsync_d;

  // Capture FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_init_done && i_enable) state_nxt = ST_ARM;
                 else                         state_nxt = ST_IDLE;
      ST_ARM:    if (vs_rise) state_nxt = ST_SYNC;
                 else         state_nxt = ST_ARM;
      ST_SYNC:   if (vs_fall) state_nxt = ST_ACTIVE;
                 else         state_nxt = ST_SYNC;
      ST_ACTIVE: if (vs_rise) state_nxt = i_enable ? ST_SYNC : ST_IDLE;
                 else         state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture FSM state register.
  always_ff @(posedge i_pclk or posedge i_cam_rst) begin
    if (i_cam_rst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Byte assembly, coordinates, crop window and error events.
  always_comb begin
    frame_start = (state == ST_SYNC) && vs_fall;
    frame_end   = (state == ST_ACTIVE) && vs_rise;
    // A line still open when vsync rises is dropped without eol or length check.
    line_end    = (state == ST_ACTIVE) && href_fall && !vs_rise;
    byte_ok     = (state == ST_ACTIVE) && href_q && !vsync_q;
    two_byte    = (cfg_fmt != FMT_RAW);
    // The first byte of a line may arrive together with href rise, before
    // the registered phase/column have been cleared.
    cur_phase   = href_rise ? 1'b0 : phase;
    cur_col     = href_rise ? COL_ZERO : col;
    pix_done    = byte_ok && (!two_byte || cur_phase);
    x_ext       = {1'b0, cur_col};
    y_ext       = {1'b0, row};
    x0_ext      = {1'b0, cfg_x0};
    y0_ext      = {1'b0, cfg_y0};
    x_end       = x0_ext + {1'b0, cfg_w};
    y_end       = y0_ext + {1'b0, cfg_h};
    in_x        = (cfg_w == COL_ZERO) || ((x_ext >= x0_ext) && (x_ext < x_end));
    in_y        = (cfg_h == COL_ZERO) || ((y_ext >= y0_ext) && (y_ext < y_end));
    emit        = pix_done && in_x && in_y;
    set_len     = (line_end && (cfg_exp != COL_ZERO) && (col != cfg_exp)) ||
                  (pix_done && (cur_col >= COL_NEAR));
    set_odd     = line_end && two_byte && phase;
  end

  pix_fmt_conv u_conv (
    .fmt     (cfg_fmt),
    .hi_byte (hold_byte),
    .lo_byte (byte_q),
    .rgb     (rgb)
  );

  // Per-frame configuration, line/frame bookkeeping and registered outputs.
  always_ff @(posedge i_pclk or posedge i_cam_rst) begin
    if (i_cam_rst) begin
      cfg_fmt        <= FMT_RGB565;
      cfg_x0         <= COL_ZERO;
      cfg_y0         <= COL_ZERO;
      cfg_w          <= COL_ZERO;
      cfg_h          <= COL_ZERO;
      cfg_exp        <= COL_ZERO;
      phase          <= 1'b0;
      col            <= COL_ZERO;
      row            <= COL_ZERO;
      hold_byte      <= 8'h00;
      line_emit      <= 1'b0;
      sof_pend       <= 1'b0;
      o_pix          <= 24'h000000;
      o_pix_valid    <= 1'b0;
      o_sof          <= 1'b0;
      o_eol          <= 1'b0;
      o_eof          <= 1'b0;
      o_frame_active <= 1'b0;
      o_frame_cnt    <= 16'h0000;
      o_err_len      <= 1'b0;
      o_err_odd      <= 1'b0;
    end else begin
      o_pix_valid    <= emit;
      o_sof          <= emit && sof_pend;
      o_eol          <= line_end && line_emit;
      o_eof          <= frame_end;
      o_frame_active <= (state_nxt == ST_ACTIVE);
      if (emit) o_pix <= rgb;
      if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
      o_err_len <= set_len | (o_err_len & ~i_err_clr);
      o_err_odd <= set_odd | (o_err_odd & ~i_err_clr);

      if (frame_start) begin
        cfg_fmt   <= i_fmt;
        cfg_x0    <= i_crop_x0;
        cfg_y0    <= i_crop_y0;
        cfg_w     <= i_crop_w;
        cfg_h     <= i_crop_h;
        cfg_exp   <= i_exp_width;
        phase     <= 1'b0;
        col       <= COL_ZERO;
        row       <= COL_ZERO;
        line_emit <= 1'b0;
        sof_pend  <= 1'b1;
      end else begin
        if (byte_ok) begin
          phase <= two_byte ? ~cur_phase : 1'b0;
          if (!cur_phase) hold_byte <= byte_q;
        end
        if (pix_done)       col <= (cur_col == COL_MAX) ? COL_MAX : cur_col + COL_ONE;
        else if (href_rise) col <= COL_ZERO;
        if (emit) begin
          line_emit <= 1'b1;
          sof_pend  <= 1'b0;
        end
        if (line_end) begin
          line_emit <= 1'b0;
          if (col != COL_ZERO) row <= row + COL_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Scoreboard bench for dvp_pixel_capture: stimulus tasks push the expected
// pixel stream into a queue, a monitor pops and compares on o_pix_valid.
module tb_dvp_pixel_capture;

  localparam int DATA_W  = 8;
  localparam int COORD_W = 12;

  logic               clk = 1'b0;
  logic               i_cam_rst, i_init_done, i_enable, i_vsync, i_href, i_err_clr;
  logic [1:0]         i_fmt;
  logic [DATA_W-1:0]  i_pdata;
  logic [COORD_W-1:0] i_crop_x0, i_crop_y0, i_crop_w, i_crop_h, i_exp_width;
  logic [23:0]        o_pix;
  logic               o_pix_valid, o_sof, o_eol, o_eof, o_frame_active;
  logic [15:0]        o_frame_cnt;
  logic               o_err_len, o_err_odd;

  dvp_pixel_capture #(.DATA_W(DATA_W), .COORD_W(COORD_W)) dut (
    .i_pclk(clk), .i_cam_rst(i_cam_rst), .i_init_done(i_init_done),
    .i_enable(i_enable), .i_fmt(i_fmt), .i_pdata(i_pdata),
    .i_vsync(i_vsync), .i_href(i_href),
    .i_crop_x0(i_crop_x0), .i_crop_y0(i_crop_y0),
    .i_crop_w(i_crop_w), .i_crop_h(i_crop_h),
    .i_exp_width(i_exp_width), .i_err_clr(i_err_clr),
    .o_pix(o_pix), .o_pix_valid(o_pix_valid), .o_sof(o_sof),
    .o_eol(o_eol), .o_eof(o_eof), .o_frame_active(o_frame_active),
    .o_frame_cnt(o_frame_cnt), .o_err_len(o_err_len), .o_err_odd(o_err_odd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic        sof;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0;
  int   eol_seen = 0, eof_seen = 0, n_popped = 0, run_len = 0, max_run = 0;
  bit   mon_off = 1'b0;
  int   exp_eol = 0, exp_eof = 0, exp_fcnt = 0;
  int   m_fmt = 0, m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0, m_row = 0;
  bit   m_sof_pend = 1'b0;
  int   base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] x5(input int v);
    return 8'(v * 8 + v / 4);
  endfunction

  function automatic logic [7:0] x6(input int v);
    return 8'(v * 4 + v / 16);
  endfunction

  // Reference conversion: b0 is the first byte of the pair, b1 the second.
  function automatic logic [23:0] mdl_conv(input int fmt, input int b0, input int b1);
    logic [23:0] res;
    int r, g, b;
    case (fmt)
      0: begin r = b0 / 8; g = (b0 % 8) * 8 + b1 / 32; b = b1 % 32;
               res = {x5(r), x6(g), x5(b)}; end
      1: begin r = (b0 / 4) % 32; g = (b0 % 4) * 8 + b1 / 32; b = b1 % 32;
               res = {x5(r), x5(g), x5(b)}; end
      2: res = {8'(b0), 8'(b0), 8'(b0)};
      default: res = {8'(b1), 8'(b1), 8'(b1)};
    endcase
    return res;
  endfunction

  function automatic logic [7:0] byte_at(input int pat, input int i);
    logic [7:0] v;
    case (pat)
      0: v = 8'(i);
      1: v = 8'hA5;
      default: v = (i % 2 == 0) ? 8'h40 : 8'h80;
    endcase
    return v;
  endfunction

  function automatic bit in_win(input int c, input int r);
    return ((m_w == 0) || (c >= m_x0 && c < m_x0 + m_w)) &&
           ((m_h == 0) || (r >= m_y0 && r < m_y0 + m_h));
  endfunction

  // One href-high line of nbytes bytes followed by a 6-cycle gap.
  task automatic send_line(input int nbytes, input int pat, input bit expect_on);
    int         held = 0;
    int         col = 0;
    bit         emitted = 1'b0;
    logic [7:0] b;
    exp_t       e;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      b = byte_at(pat, i);
      i_pdata = b;
      i_href = 1'b1;
      if (m_fmt == 3 || i % 2 == 1) begin
        if (expect_on && in_win(col, m_row)) begin
          e.pix = mdl_conv(m_fmt, held, int'(b));
          e.sof = m_sof_pend;
          exp_q.push_back(e);
          m_sof_pend = 1'b0;
          emitted = 1'b1;
        end
        col++;
      end else begin
        held = int'(b);
      end
    end
    @(negedge clk);
    i_href = 1'b0;
    i_pdata = 8'h00;
    if (emitted) exp_eol++;
    if (col > 0) m_row++;
    repeat (6) @(negedge clk);
  endtask

  // vsync high for 4 cycles; the model latches the frame configuration on the fall.
  task automatic vsync_pulse(input bit was_active);
    @(negedge clk);
    i_vsync = 1'b1;
    if (was_active) begin
      exp_eof++;
      exp_fcnt++;
    end
    repeat (4) @(negedge clk);
    i_vsync = 1'b0;
    m_fmt = int'(i_fmt);
    m_x0 = int'(i_crop_x0);
    m_y0 = int'(i_crop_y0);
    m_w = int'(i_crop_w);
    m_h = int'(i_crop_h);
    m_row = 0;
    m_sof_pend = 1'b1;
    repeat (3) @(negedge clk);
    chk("eof_count", eof_seen, exp_eof);
    chk("frame_cnt", o_frame_cnt, exp_fcnt);
  endtask

  task automatic err_clear();
    @(negedge clk);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every valid pixel and counts markers.
  always @(posedge clk) begin
    #1;
    if (o_pix_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (o_eol) eol_seen++;
    if (o_eof) eof_seen++;
    if (o_pix_valid && !mon_off) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_unexpected: got %06h with nothing expected (t=%0t)", o_pix, $time);
      end else begin
        mon_e = exp_q.pop_front();
        n_popped++;
        chk("pix", o_pix, mon_e.pix);
        chk("sof", o_sof, mon_e.sof);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_cam_rst = 1'b1; i_init_done = 1'b0; i_enable = 1'b1; i_fmt = 2'd0;
    i_pdata = 8'h00; i_vsync = 1'b0; i_href = 1'b0; i_err_clr = 1'b0;
    i_crop_x0 = 12'd0; i_crop_y0 = 12'd0; i_crop_w = 12'd0; i_crop_h = 12'd0;
    i_exp_width = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {o_pix, o_pix_valid, o_sof, o_eol, o_eof, o_frame_active,
                        o_frame_cnt, o_err_len, o_err_odd}, 64'd0);
    i_cam_rst = 1'b0;

    // init_done arrives mid-frame: nothing until a full vsync rise/fall.
    vsync_pulse(1'b0);
    send_line(20, 0, 1'b0);
    i_init_done = 1'b1;
    send_line(20, 0, 1'b0);
    chk("armed_not_active", o_frame_active, 1'b0);
    vsync_pulse(1'b0);
    chk("active_after_vsync", o_frame_active, 1'b1);

    // Basic RGB565, 125 pixels per line.
    for (int l = 0; l < 3; l++) send_line(250, 0, 1'b1);
    chk("basic_eol", eol_seen, exp_eol);
    chk("basic_errs", {o_err_len, o_err_odd}, 2'b00);
    chk("basic_drained", exp_q.size(), 0);
    vsync_pulse(1'b1);

    // Format change mid-frame only applies to the next frame.
    send_line(20, 0, 1'b1);
    i_fmt = 2'd3;
    send_line(20, 0, 1'b1);
    vsync_pulse(1'b1);
    max_run = 0;
    send_line(8, 1, 1'b1);
    send_line(8, 1, 1'b1);
    chk("raw_rate", max_run, 8);

    // YUV422 luma.
    i_fmt = 2'd2;
    vsync_pulse(1'b1);
    send_line(8, 2, 1'b1);
    send_line(8, 2, 1'b1);

    // Crop window 4x3 at (10,2).
    i_fmt = 2'd0;
    i_crop_x0 = 12'd10; i_crop_w = 12'd4; i_crop_y0 = 12'd2; i_crop_h = 12'd3;
    vsync_pulse(1'b1);
    base = n_popped;
    for (int l = 0; l < 6; l++) send_line(40, 0, 1'b1);
    chk("crop_count", n_popped - base, 12);
    chk("crop_eol", eol_seen, exp_eol);

    // Length error.
    i_crop_x0 = 12'd0; i_crop_w = 12'd0; i_crop_y0 = 12'd0; i_crop_h = 12'd0;
    i_exp_width = 12'd124;
    vsync_pulse(1'b1);
    send_line(250, 0, 1'b1);
    chk("err_len_set", o_err_len, 1'b1);
    chk("err_odd_clean", o_err_odd, 1'b0);
    err_clear();
    chk("err_len_clr", o_err_len, 1'b0);

    // Odd byte count.
    i_exp_width = 12'd0;
    vsync_pulse(1'b1);
    send_line(249, 0, 1'b1);
    chk("err_odd_set", o_err_odd, 1'b1);
    chk("err_len_clean", o_err_len, 1'b0);
    err_clear();
    chk("errs_clr", {o_err_len, o_err_odd}, 2'b00);
    vsync_pulse(1'b1);

    // Asynchronous reset in the middle of a line.
    mon_off = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      i_pdata = 8'(i);
      i_href = 1'b1;
    end
    @(posedge clk);
    #2 i_cam_rst = 1'b1;
    #1 chk("async_rst_outputs", {o_pix, o_pix_valid, o_sof, o_eol, o_eof, o_frame_active,
                                 o_frame_cnt, o_err_len, o_err_odd}, 64'd0);
    @(negedge clk);
    i_href = 1'b0;
    i_pdata = 8'h00;
    repeat (2) @(negedge clk);
    i_cam_rst = 1'b0;
    exp_q.delete();
    exp_fcnt = 0;
    @(negedge clk);
    mon_off = 1'b0;
    vsync_pulse(1'b0);
    send_line(20, 0, 1'b1);
    chk("rearm_active", o_frame_active, 1'b1);

    // Disable mid-frame: frame completes, then IDLE.
    i_enable = 1'b0;
    send_line(20, 0, 1'b1);
    vsync_pulse(1'b1);
    chk("disabled_idle", o_frame_active, 1'b0);
    send_line(20, 0, 1'b0);
    vsync_pulse(1'b0);
    send_line(20, 0, 1'b0);
    chk("idle_stays", o_frame_active, 1'b0);

    chk("final_eol", eol_seen, exp_eol);
    chk("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
